// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared state encoding and select constants for mux_sel_arbiter
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_pointer.sv
// rtl/rr_pointer.sv - 1-bit round-robin priority pointer, updated when a grant is released
import mux_sel_pkg::*;

module rr_pointer (
  input  logic clk,
  input  logic rst,
  input  logic release_grant,
  input  logic served,
  output logic ptr
);

  // ptr names the favoured source; the one just served drops to lowest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SEL_A;
    end else if (release_grant) begin
      ptr <= ~served;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-source burst round-robin arbiter driving a 2:1 mux select
// Optional burst limit enabled with `define MUX_SEL_BURST_LIMIT_EN
import mux_sel_pkg::*;

module mux_sel_arbiter #(
  parameter  int MAX_BURST = 16,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             last_a,
  input  logic             last_b,
  input  logic             beat,
  output logic             sel,
  output logic             grant_a,
  output logic             grant_b,
  output logic             abort,
  output logic [CNT_W-1:0] beat_cnt
);

  arb_state_t       state, state_n;
  logic             sel_n, grant_a_n, grant_b_n, abort_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;
  logic             rel, served, ptr;
  logic             at_limit, done_a, done_b;

  rr_pointer u_ptr (
    .clk           (clk),
    .rst           (rst),
    .release_grant (rel),
    .served        (served),
    .ptr           (ptr)
  );

  assign cnt_inc = (beat_cnt == CNT_W'(MAX_BURST)) ? beat_cnt : beat_cnt + CNT_W'(1);

`ifdef MUX_SEL_BURST_LIMIT_EN
  assign at_limit = (beat_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign at_limit = 1'b0;
`endif

  // Hitting the burst limit closes the grant exactly like a last beat
  assign done_a = beat && (last_a || at_limit);
  assign done_b = beat && (last_b || at_limit);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    abort_n = 1'b0;
    cnt_n   = beat_cnt;
    rel     = 1'b0;
    served  = SEL_A;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || ptr == SEL_A)) begin
          state_n = GNT_A;
        end else if (req_b) begin
          state_n = GNT_B;
        end
      end
      GNT_A: begin
        if (beat) cnt_n = cnt_inc;
        if (done_a) begin
          rel     = 1'b1;
          served  = SEL_A;
          state_n = req_b ? GNT_B : IDLE;
        end else if (!req_a) begin
          rel     = 1'b1;
          served  = SEL_A;
          state_n = IDLE;
          abort_n = 1'b1;
        end
      end
      GNT_B: begin
        if (beat) cnt_n = cnt_inc;
        if (done_b) begin
          rel     = 1'b1;
          served  = SEL_B;
          state_n = req_a ? GNT_A : IDLE;
        end else if (!req_b) begin
          rel     = 1'b1;
          served  = SEL_B;
          state_n = IDLE;
          abort_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // sel moves only on grant entry, so it holds through IDLE
    if (state_n == GNT_A && state != GNT_A) begin
      sel_n = SEL_A;
      cnt_n = '0;
    end else if (state_n == GNT_B && state != GNT_B) begin
      sel_n = SEL_B;
      cnt_n = '0;
    end
    grant_a_n = (state_n == GNT_A);
    grant_b_n = (state_n == GNT_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_A;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      abort    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      grant_a  <= grant_a_n;
      grant_b  <= grant_b_n;
      abort    <= abort_n;
      beat_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard bench for mux_sel_arbiter with MAX_BURST=4
module tb_mux_sel_arbiter;

`ifdef MUX_SEL_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, last_a, last_b, beat;
  logic       sel, grant_a, grant_b, abort;
  logic [2:0] beat_cnt;

  logic [6:0] exp_q[$];
  int         id_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_step = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .last_a   (last_a),
    .last_b   (last_b),
    .beat     (beat),
    .sel      (sel),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .abort    (abort),
    .beat_cnt (beat_cnt)
  );

  function automatic logic [6:0] e(input logic s, ga, gb, ab, input logic [2:0] c);
    return {s, ga, gb, ab, c};
  endfunction

  // Monitor: every cycle is an output sample; pop and compare away from the edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] x, act;
      int         id;
      x   = exp_q.pop_front();
      id  = id_q.pop_front();
      act = {sel, grant_a, grant_b, abort, beat_cnt};
      n_cmp++;
      if (act !== x) begin
        n_fail++;
        $display("FAIL step%0d {sel,ga,gb,abort,cnt}: got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                 id, act[6], act[5], act[4], act[3], act[2:0], x[6], x[5], x[4], x[3], x[2:0]);
      end
    end
  end

  task automatic step(input logic r, ra, rb, la, lb, bt, input logic [6:0] x);
    rst = r; req_a = ra; req_b = rb; last_a = la; last_b = lb; beat = bt;
    @(posedge clk);
    exp_q.push_back(x);
    id_q.push_back(n_step);
    n_step++;
    #1;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0; beat = 1'b0;
    @(posedge clk); #1;
    //   rst ra rb la lb bt       sel ga gb ab cnt
    step(1, 0, 0, 0, 0, 0,   e(0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0,   e(0, 1, 0, 0, 0));
    step(0, 1, 0, 0, 0, 1,   e(0, 1, 0, 0, 1));
    step(0, 1, 0, 0, 0, 1,   e(0, 1, 0, 0, 2));
    step(0, 1, 0, 1, 0, 1,   e(0, 0, 0, 0, 3));
    step(0, 0, 0, 0, 0, 0,   e(0, 0, 0, 0, 3));
    step(0, 0, 0, 1, 0, 1,   e(0, 0, 0, 0, 3));
    // both requesting from reset: alternation with no IDLE bubble
    step(1, 0, 0, 0, 0, 0,   e(0, 0, 0, 0, 0));
    step(0, 1, 1, 0, 0, 0,   e(0, 1, 0, 0, 0));
    step(0, 1, 1, 1, 0, 1,   e(1, 0, 1, 0, 0));
    step(0, 1, 1, 0, 0, 1,   e(1, 0, 1, 0, 1));
    step(0, 1, 1, 0, 1, 1,   e(0, 1, 0, 0, 0));
    step(0, 1, 1, 1, 0, 1,   e(1, 0, 1, 0, 0));
    // abort in GNT_B after two beats; sel holds, pointer favours A
    step(0, 0, 1, 0, 0, 1,   e(1, 0, 1, 0, 1));
    step(0, 0, 1, 0, 0, 1,   e(1, 0, 1, 0, 2));
    step(0, 0, 0, 0, 0, 0,   e(1, 0, 0, 1, 2));
    step(0, 0, 0, 0, 0, 0,   e(1, 0, 0, 0, 2));
    step(0, 1, 1, 0, 0, 0,   e(0, 1, 0, 0, 0));
    step(0, 1, 1, 1, 0, 1,   e(1, 0, 1, 0, 0));
    // last together with req drop is a normal completion
    step(0, 0, 0, 0, 1, 1,   e(1, 0, 0, 0, 1));
    // reset mid-grant
    step(0, 0, 1, 0, 0, 0,   e(1, 0, 1, 0, 0));
    step(0, 0, 1, 0, 0, 1,   e(1, 0, 1, 0, 1));
    step(0, 0, 1, 0, 0, 1,   e(1, 0, 1, 0, 2));
    step(0, 0, 1, 0, 0, 1,   e(1, 0, 1, 0, 3));
    step(1, 0, 1, 0, 0, 1,   e(0, 0, 0, 0, 0));
    // both held, no last: burst limit switches to B, else saturates at 4
    step(0, 1, 1, 0, 0, 0,   e(0, 1, 0, 0, 0));
    step(0, 1, 1, 0, 0, 1,   e(0, 1, 0, 0, 1));
    step(0, 1, 1, 0, 0, 1,   e(0, 1, 0, 0, 2));
    step(0, 1, 1, 0, 0, 1,   e(0, 1, 0, 0, 3));
    step(0, 1, 1, 0, 0, 1,   LIM ? e(1, 0, 1, 0, 0) : e(0, 1, 0, 0, 4));
    step(0, 1, 1, 0, 0, 1,   LIM ? e(1, 0, 1, 0, 1) : e(0, 1, 0, 0, 4));
    step(0, 1, 1, 0, 0, 1,   LIM ? e(1, 0, 1, 0, 2) : e(0, 1, 0, 0, 4));
    // A alone: limit re-grants via IDLE with cleared count
    step(1, 0, 0, 0, 0, 0,   e(0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0,   e(0, 1, 0, 0, 0));
    step(0, 1, 0, 0, 0, 1,   e(0, 1, 0, 0, 1));
    step(0, 1, 0, 0, 0, 1,   e(0, 1, 0, 0, 2));
    step(0, 1, 0, 0, 0, 1,   e(0, 1, 0, 0, 3));
    step(0, 1, 0, 0, 0, 1,   LIM ? e(0, 0, 0, 0, 4) : e(0, 1, 0, 0, 4));
    step(0, 1, 0, 0, 0, 0,   LIM ? e(0, 1, 0, 0, 0) : e(0, 1, 0, 0, 4));

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
